adder_seq: RTL and testbench

Multi-cycle, chunk-serial integer adder/subtractor for the RV64 ALU datapath. It processes `CHUNK` bits per clock and trades latency for a short carry chain. Operands are taken and results returned over valid/ready handshakes. Alongside the sum it produces carry-out, signed-overflow and zero flags, and it supports an optional RV64 word mode (ADDW/SUBW).

---
 rtl/adder_seq.sv | 139 +++++++++++++
 tb/tb_adder_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/adder_seq.sv
// Chunk-serial adder/subtractor: CHUNK bits per cycle, valid/ready in and out, with carry/overflow/zero flags.
// Define ADDER_SEQ_WORD_MODE_EN to honour the word (ADDW/SUBW) input; otherwise word is ignored.
module adder_seq #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             word,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             c_o,
   output logic             ovf,
   output logic             zero
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDX_W-1:0] LAST_FULL = IDX_W'(NCHUNK - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic             word_r;
   logic             carry;
   logic [IDX_W-1:0] idx;
   logic             word_eff;

`ifdef ADDER_SEQ_WORD_MODE_EN
   localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(32 / CHUNK - 1);
   assign word_eff = word;
`else
   logic word_unused;
   assign word_unused = word;
   assign word_eff    = 1'b0;
`endif

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   logic [31:0]      base;
   logic [CHUNK-1:0] a_ch;
   logic [CHUNK-1:0] b_ch;
   logic [CHUNK-1:0] sum_ch;
   logic             cout_ch;
   logic             last;
   logic [WIDTH-1:0] s_nxt;
   logic [WIDTH-1:0] s_fin;
   logic             a_m;
   logic             b_m;
   logic             s_m;

   always_comb begin
      base              = 32'(idx) * 32'(CHUNK);
      a_ch              = a_r[base +: CHUNK];
      b_ch              = b_r[base +: CHUNK];
      {cout_ch, sum_ch} = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry};
      s_nxt             = s;
      s_nxt[base +: CHUNK] = sum_ch;
      s_fin             = s_nxt;
      last              = (idx == LAST_FULL);
      a_m               = a_r[WIDTH-1];
      b_m               = b_r[WIDTH-1];
      s_m               = s_nxt[WIDTH-1];
`ifdef ADDER_SEQ_WORD_MODE_EN
      // Word ops stop at bit 31 and sign-extend the 32-bit result
      if (word_r) begin
         last  = (idx == LAST_WORD);
         s_fin = {{(WIDTH-32){s_nxt[31]}}, s_nxt[31:0]};
         a_m   = a_r[31];
         b_m   = b_r[31];
         s_m   = s_nxt[31];
      end
`endif
   end

   // Operand capture stage: data only, no reset needed
   always_ff @(posedge clk) begin
      if (state == IDLE && in_valid) begin
         a_r <= a;
         b_r <= b ^ {WIDTH{sub}};
      end
   end

   // Control and result stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         idx    <= '0;
         carry  <= 1'b0;
         word_r <= 1'b0;
         s      <= '0;
         c_o    <= 1'b0;
         ovf    <= 1'b0;
         zero   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  word_r <= word_eff;
                  carry  <= sub;
                  idx    <= '0;
                  s      <= '0;
                  c_o    <= 1'b0;
                  ovf    <= 1'b0;
                  zero   <= 1'b0;
                  state  <= BUSY;
               end
            end
            BUSY: begin
               carry <= cout_ch;
               idx   <= idx + 1'b1;
               if (last) begin
                  s     <= s_fin;
                  c_o   <= cout_ch;
                  ovf   <= (a_m ^ s_m) & (b_m ^ s_m);
                  zero  <= (s_fin == '0);
                  state <= DONE;
               end else begin
                  s <= s_nxt;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adder_seq.sv
// Scoreboard bench for adder_seq: stimulus pushes expected results, a monitor pops and checks on out_valid.
module tb_adder_seq;

   localparam int WIDTH = 64;
   localparam int CHUNK = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             sub = 1'b0;
   logic             word = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] s;
   logic             c_o;
   logic             ovf;
   logic             zero;

   adder_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub), .word(word),
      .out_valid(out_valid), .out_ready(out_ready),
      .s(s), .c_o(c_o), .ovf(ovf), .zero(zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] s;
      logic        c;
      logic        o;
      logic        z;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [63:0] es, input logic ec, input logic eo,
                               input logic ez, input int lat);
      exp_t e;
      e.s = es; e.c = ec; e.o = eo; e.z = ez; e.lat = lat; e.acc = 0;
      return e;
   endfunction

   // Monitor: pop on each new result, then keep checking it while it is held
   exp_t cur;
   logic have_cur = 1'b0;
   logic ov_prev = 1'b0;
   always @(negedge clk) begin
      if (out_valid && !ov_prev) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_result: got s=%h with empty scoreboard", s);
            have_cur = 1'b0;
         end else begin
            cur = sb.pop_front();
            have_cur = 1'b1;
            chk("s", s, cur.s);
            chk("c_o", 64'(c_o), 64'(cur.c));
            chk("ovf", 64'(ovf), 64'(cur.o));
            chk("zero", 64'(zero), 64'(cur.z));
            chk("latency", 64'(cyc - cur.acc), 64'(cur.lat));
         end
      end else if (out_valid && have_cur) begin
         chk("hold_s", s, cur.s);
         chk("hold_flags", {61'd0, c_o, ovf, zero}, {61'd0, cur.c, cur.o, cur.z});
      end
      ov_prev = out_valid;
   end

   task automatic issue(input logic [63:0] ta, input logic [63:0] tb_v, input logic ts,
                        input logic tw, input exp_t e);
      int n;
      @(negedge clk); #1;
      a = ta; b = tb_v; sub = ts; word = tw; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      if (!in_ready) begin
         n_cmp++; n_err++;
         $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
      end
      @(posedge clk); #1;
      e.acc = cyc;
      sb.push_back(e);
      in_valid = 1'b0;
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!out_valid && n < 40) begin @(negedge clk); n++; end
      if (!out_valid) begin
         n_cmp++; n_err++;
         $display("FAIL out_valid_timeout: out_valid=%b required 1", out_valid);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      chk("rst_s", s, 64'd0);
      chk("rst_flags", {61'd0, c_o, ovf, zero}, 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk); #1 rst_n = 1'b1;

      issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, mk(64'd0, 1, 0, 1, 4));
      wait_valid();
      issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, mk(64'h8000_0000_0000_0000, 0, 1, 0, 4));
      wait_valid();
      issue(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0, mk(64'h7FFF_FFFF_FFFF_FFFF, 1, 1, 0, 4));
      wait_valid();
      issue(64'd5, 64'd7, 1'b1, 1'b0, mk(64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 4));
      wait_valid();
      issue(64'd7, 64'd5, 1'b1, 1'b0, mk(64'd2, 1, 0, 0, 4));
      wait_valid();

      // Backpressure with ignored in_valid pulses
      @(negedge clk); #1 out_ready = 1'b0;
      issue(64'h1234, 64'h1111, 1'b0, 1'b0, mk(64'h2345, 0, 0, 0, 4));
      wait_valid();
      for (int i = 0; i < 10; i++) begin
         chk("bp_out_valid", 64'(out_valid), 64'd1);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk("bp_s", s, 64'h2345);
         #1;
         if (i == 2 || i == 5) begin
            a = 64'hFFFF_0000_FFFF_0000; b = 64'h0F0F; sub = 1'b1; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
      end
      #1 in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_out_valid", 64'(out_valid), 64'd0);
      chk("bp_release_in_ready", 64'(in_ready), 64'd1);
      chk("bp_release_s", s, 64'h2345);
      issue(64'd0, 64'd0, 1'b0, 1'b0, mk(64'd0, 0, 0, 1, 4));
      wait_valid();

      // Reset during the second BUSY cycle discards the operation
      issue(64'd9, 64'd9, 1'b0, 1'b0, mk(64'd18, 0, 0, 0, 4));
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      void'(sb.pop_back());
      chk("midrst_s", s, 64'd0);
      chk("midrst_flags", {61'd0, c_o, ovf, zero}, 64'd0);
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      issue(64'd3, 64'd4, 1'b0, 1'b0, mk(64'd7, 0, 0, 0, 4));
      wait_valid();

`ifdef ADDER_SEQ_WORD_MODE_EN
      issue(64'h0000_0000_7FFF_FFFF, 64'd1, 1'b0, 1'b1, mk(64'hFFFF_FFFF_8000_0000, 0, 1, 0, 2));
`else
      issue(64'h0000_0000_7FFF_FFFF, 64'd1, 1'b0, 1'b1, mk(64'h0000_0000_8000_0000, 0, 0, 0, 4));
`endif
      wait_valid();

      repeat (6) @(negedge clk);
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
